// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM arbiter between instruction fetch and the MEM stage.
// IF reads pass straight through; MEM loads/stores are sequenced a byte per cycle and stall the pipeline.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [7:0]        mem_ctrl_data,
  output logic [1:0]        if_or_mem_o,
  input  logic [1:0]        mem_request,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [1:0]        mem_width,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              stall_req_o,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic [2:0]        n_q;
  logic [2:0]        n_sel;
  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_if_addr;
  logic [31:0]       wdata_q;
  logic              mem_load, mem_store, mem_req;

  assign mem_load      = (mem_request == 2'b01);
  assign mem_store     = (mem_request == 2'b10);
  assign mem_req       = mem_load | mem_store;
  assign mem_ctrl_data = ram_din;
  // Byte issued at cnt-1 is on ram_din while cnt is current; cnt==N wraps to lane 3.
  assign cap_idx       = cnt[1:0] - 2'd1;

  always_comb begin
    unique case (mem_width)
      2'b00:   n_sel = 3'd1;
      2'b01:   n_sel = 3'd2;
      default: n_sel = 3'd4;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    ram_addr    = '0;
    ram_wr      = 1'b0;
    ram_dout    = '0;
    if_or_mem_o = 2'b00;
    stall_req_o = 1'b0;
    unique case (state)
      IDLE: begin
        ram_addr = if_addr;
        if (mem_req) begin
          stall_req_o = 1'b1;
          if_or_mem_o = 2'b10;
          state_nxt   = mem_load ? READ : WRITE;
        end else if (if_request) begin
          if_or_mem_o = 2'b01;
        end
      end
      READ: begin
        stall_req_o = 1'b1;
        if_or_mem_o = 2'b10;
        ram_addr    = addr_q + ADDR_W'(cnt);
        if (cnt == n_q) state_nxt = DONE;
      end
      WRITE: begin
        stall_req_o = 1'b1;
        if_or_mem_o = 2'b10;
        ram_wr      = 1'b1;
        ram_addr    = addr_q + ADDR_W'(cnt);
        ram_dout    = wdata_q[{cnt[1:0], 3'b000} +: 8];
        if (cnt == n_q - 3'd1) state_nxt = DONE;
      end
      DONE: begin
        // Re-fetch the byte IF had in flight when MEM took the bus.
        if_or_mem_o = 2'b10;
        ram_addr    = last_if_addr;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset blanks the bus immediately so an aborted store cannot write further bytes.
    if (rst) begin
      ram_addr    = '0;
      ram_wr      = 1'b0;
      ram_dout    = '0;
      if_or_mem_o = 2'b00;
      stall_req_o = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      n_q          <= 3'd1;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_if_addr <= '0;
      mem_rdata_o  <= '0;
      mem_done_o   <= 1'b0;
    end else begin
      state      <= state_nxt;
      mem_done_o <= (state_nxt == DONE);
      unique case (state)
        IDLE: begin
          if (mem_req) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            n_q     <= n_sel;
            cnt     <= '0;
            if (mem_load) mem_rdata_o <= '0;
          end else if (if_request) begin
            last_if_addr <= if_addr;
          end
        end
        READ: begin
          cnt <= cnt + 3'd1;
          if (cnt != 3'd0) mem_rdata_o[{cap_idx, 3'b000} +: 8] <= ram_din;
        end
        WRITE:   cnt <= cnt + 3'd1;
        DONE:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port byte-wide RAM arbiter between the instruction-fetch stage (byte-per-cycle fetch) and the MEM stage (1/2/4-byte load/store).
- IF requests pass straight through. MEM requests are sequenced internally and take priority; the pipeline is stalled while one is in flight.
- Returns RAM bytes to IF, assembled words to MEM, and reports the current bus owner on if_or_mem_o.

Parameters:
- ADDR_W, 32, address width for if_addr, mem_addr and ram_addr.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- if_request  in  1  IF wants a byte read at if_addr this cycle.
- if_addr  in  ADDR_W  IF byte address.
- mem_ctrl_data  out  8  RAM read byte forwarded to IF.
- if_or_mem_o  out  2  bus owner this cycle: 01 IF, 10 MEM, 00 none.
- mem_request  in  2  00 none, 01 load, 10 store, 11 illegal (treated as none).
- mem_addr  in  ADDR_W  MEM base byte address.
- mem_wdata  in  32  store data, little-endian.
- mem_width  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_rdata_o  out  32  assembled load data, zero-extended.
- mem_done_o  out  1  one-cycle pulse: access complete.
- stall_req_o  out  1  to ctrl; freezes IF and the pipeline.
- ram_din  in  8  RAM read data.
- ram_dout  out  8  RAM write data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wr  out  1  1 write, 0 read.

Behaviour:
- RAM timing: RAM samples ram_addr/ram_wr/ram_dout at the rising edge; read data is valid on ram_din throughout the following cycle.
- mem_ctrl_data = ram_din combinationally, at all times.
- Reset values: state IDLE, cnt 0, mem_rdata_o 0, mem_done_o 0, last_if_addr 0. Combinational outputs in reset: ram_wr 0, ram_addr 0, ram_dout 0, if_or_mem_o 00, stall_req_o 0.
- N = 1/2/4 for mem_width 00/01/10 (11 gives 4).
- States: IDLE, READ, WRITE, DONE.
- IDLE, no MEM request:
  - ram_addr = if_addr, ram_wr = 0.
  - if_or_mem_o = 01 if if_request, else 00.
  - At each edge with if_request high, last_if_addr <= if_addr.
- IDLE with mem_request 01 or 10:
  - stall_req_o = 1 combinationally in that same cycle.
  - At the edge: latch addr_q, wdata_q and N; cnt <= 0; go to READ or WRITE.
  - IF is not served in that cycle: if_or_mem_o = 10, ram_addr = if_addr, ram_wr = 0.
- READ:
  - Issue phase: cnt 0..N-1 drives ram_addr = addr_q+cnt.
  - Byte k is captured into mem_rdata_o[8k+7:8k] at the end of the cycle after its issue.
  - One extra capture cycle after the last issue, then DONE.
  - Total N+1 cycles in READ. Upper unused bytes are cleared at accept.
- WRITE:
  - N cycles with ram_wr = 1, ram_addr = addr_q+cnt, ram_dout = wdata_q[8cnt+7:8cnt].
  - Then DONE.
- DONE (1 cycle):
  - mem_done_o = 1 (registered pulse), stall_req_o = 0.
  - ram_wr = 0, ram_addr = last_if_addr, so IF's in-flight byte is re-fetched and valid on ram_din in the first IDLE cycle.
  - mem_request is ignored in DONE; MEM must drop its request on seeing mem_done_o.
  - Next state IDLE.
- stall_req_o = 1 in READ/WRITE and in IDLE with a pending request; 0 otherwise.
- if_or_mem_o = 10 in READ/WRITE/DONE.
- mem_rdata_o holds its value until the next load is accepted.
- Address arithmetic is modulo 2^ADDR_W (wrap from 0xFFFFFFFF to 0).
- Reset mid-access: abort immediately to IDLE. No further RAM writes; a partial store is not rolled back.
- A new request in the first IDLE cycle after DONE is accepted normally.

Test Plan:
- IF stream: if_request=1, if_addr 0,1,2,3 on consecutive cycles, RAM holds 0x13,0x05,0x10,0x00 -> mem_ctrl_data shows the same bytes one cycle later each; if_or_mem_o=01; stall_req_o=0.
- Word load: mem_addr=0x100, width=10, RAM 0x100..0x103 = 0xEF,0xBE,0xAD,0xDE -> ram_addr 0x100..0x103 over 4 cycles; mem_done_o pulses at accept+6 cycles; mem_rdata_o=0xDEADBEEF; stall_req_o high until DONE.
- Half store: addr=0x201, wdata=0x1234ABCD, width=01 -> ram_wr=1 two cycles, writing 0xCD at 0x201 and 0xAB at 0x202; 0x203 unchanged; done pulse follows.
- Byte load after word load: width=00 at 0x102 -> mem_rdata_o=0x000000AD, upper bytes cleared.
- Preemption: IF fetching if_addr=0x40 when a load arrives -> in the DONE cycle ram_addr=0x40; byte at 0x40 appears on mem_ctrl_data in the first IDLE cycle.
- Reset during WRITE after 1 of 4 bytes -> state IDLE, ram_wr=0 while reset is asserted, only the first byte written, no mem_done_o.
